scan_trigger_sequencer: RTL
===========================

// Module: scan_trigger_sequencer
// PURPOSE
//  Consumes the frame configuration latched by the BRAM frame parser and runs one OCT scan from it.
//  Per point: fetches the X-galvo sample from BRAM, loads the X DAC, fires the acquisition and CCD triggers.
//  Per line: steps the Y DAC. Sits between the frame parser (upstream) and the DAC/ADC/CCD pins (downstream).
// PARAMETERS
//  ADDR_W     13       BRAM byte-address width
//  DATA_W     16       BRAM word / DAC / config width
//  X_BASE     13'd16   byte address of X sample 0 (first word after the config block)
//  ADDR_STEP  2        byte increment per 16-bit sample
// PORTS
//  clk               in   1       system clock
//  rst               in   1       asynchronous, active-high reset
//  frame_done        in   1       parser config-valid level; its rising edge starts a scan
//  abort             in   1       synchronous abort; dominant over all else except rst
//  cfg_x_points      in   16      X points per line
//  cfg_x_blocks      in   16      repeats of each line (averaging)
//  cfg_y_points      in   16      lines per frame
//  cfg_cycles_pp     in   16      active cycles per point
//  cfg_da_delay      in   16      point-cycle index of xdac_load
//  cfg_acq_delay     in   16      point-cycle index of acq_trig
//  cfg_ccd_delay     in   16      point-cycle index of ccd_trig
//  bram_addr         out  ADDR_W  BRAM read address; 1-cycle read latency
//  bram_data         in   DATA_W  BRAM read data
//  xdac_data         out  16      X DAC code, held between loads
//  xdac_load         out  1       1-cycle X DAC load strobe
//  ydac_data         out  16      Y DAC code = current line index
//  ydac_load         out  1       1-cycle Y DAC load strobe
//  acq_trig, ccd_trig out 1       1-cycle trigger pulses
//  busy              out  1       high from LOAD until DONE inclusive
//  scan_done         out  1       1-cycle pulse at normal completion
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; config registers 0; frame_done edge detector cleared.
//  - Start: rising edge of frame_done (registered, 1-cycle detect), taken only in IDLE; edges while busy are ignored.
//  - FSM: IDLE -> LOAD -> LINE -> FETCH -> CAPT -> POINT -> (FETCH | LINE | DONE) -> IDLE.
//  - LOAD: latch all cfg_* (scan is immune to later cfg changes); clear x/y/block counters.
//    Any of x_points, x_blocks, y_points == 0 -> DONE directly; no strobes fired.
//    Effective cycles_pp = max(cfg_cycles_pp, 1).
//  - LINE: ydac_data <= y_idx; ydac_load pulses once, on the first block of each line only; go to FETCH.
//  - FETCH: bram_addr <= X_BASE + ADDR_STEP*x_idx (mod 2^ADDR_W; wrap allowed).
//  - CAPT: register bram_data into sample_q.
//  - POINT: point counter pc runs 0..cycles_pp-1; the corresponding pulse fires in the cycle pc equals
//    da_delay (xdac_data <= sample_q with xdac_load), acq_delay (acq_trig) or ccd_delay (ccd_trig).
//    Equal delays -> pulses fire in the same cycle. Delay >= cycles_pp -> that pulse never fires.
//    Point period = cycles_pp + 2 clocks (FETCH, CAPT overhead).
//  - Point end (pc == cycles_pp-1), counters in priority order:
//    - x_idx < x_points-1: x_idx++ -> FETCH.
//    - else x_idx = 0; block < x_blocks-1: block++ -> FETCH.
//    - else block = 0; y_idx < y_points-1: y_idx++ -> LINE.
//    - else -> DONE.
//  - DONE: scan_done = 1 for one cycle, busy still high; -> IDLE next cycle. xdac/ydac data hold last values.
//  - abort: FSM -> IDLE next edge; strobes/busy 0 that cycle; no scan_done; DAC data hold. Abort in IDLE = no-op.
//  - Counters 16-bit; compares use registered config; no arithmetic overflow is possible at max 0xFFFF.
//  - rst mid-scan: immediate return to the reset state; a new frame_done rising edge is needed to restart.
// STRUCTURE
//  - Shared package oct_scan_pkg: state enum, X_BASE/ADDR_STEP defaults, DATA_W.
//  - One sub-module, point_timer: pc counter plus three delay comparators producing the load/acq/ccd pulses.
//  - Top level keeps the FSM, index counters, BRAM address generation and the DAC registers.
// TESTING
//  - x=4, blk=1, y=2, cpp=10, da=0, acq=3, ccd=5, BRAM[16..22]=A,B,C,D -> 8 xdac_load
//    (A,B,C,D,A,B,C,D), 8 acq/ccd; 2 ydac_load (0,1); acq 3 cycles after load; point period 12.
//  - blk=3, x=2, y=1 -> 6 points, X order A,B,A,B,A,B; exactly 1 ydac_load; scan_done once.
//  - y_points=0 -> busy high for LOAD+DONE only; scan_done pulse; zero DAC/trigger strobes.
//  - cpp=4, acq=4, ccd=2, da=2 -> no acq_trig; ccd_trig and xdac_load in the same cycle, pc=2.
//  - abort at point 3 of 8 -> busy 0 next cycle; no scan_done; xdac_data holds sample 2; a new edge restarts at x=0,y=0.
//  - frame_done toggled mid-scan, cfg changed mid-scan -> ignored; scan uses latched values; rst mid-POINT -> all outputs 0.

Source files
------------

// File: rtl/oct_scan_pkg.sv
// Shared definitions for the OCT scan datapath: widths, X sample layout
// in BRAM, and the scan sequencer state encoding.
package oct_scan_pkg;

    localparam int OCT_DATA_W    = 16;
    localparam int OCT_ADDR_W    = 13;
    localparam int OCT_ADDR_STEP = 2;

    localparam logic [OCT_ADDR_W-1:0] OCT_X_BASE = 13'd16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_LINE  = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_CAPT  = 3'd4;
    localparam logic [2:0] S_POINT = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

endpackage

// File: rtl/scan_trigger_sequencer_point_timer.sv
// Per-point cycle counter with the X DAC load, acquisition and CCD
// trigger comparators.
import oct_scan_pkg::*;

module point_timer #(
    parameter int W = OCT_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_run,
    input  logic         i_abort,
    input  logic [W-1:0] i_cpp,
    input  logic [W-1:0] i_da,
    input  logic [W-1:0] i_acq,
    input  logic [W-1:0] i_ccd,
    output logic         o_last,
    output logic         o_da_set,
    output logic         o_da,
    output logic         o_acq,
    output logic         o_ccd
);

    logic [W-1:0] r_pc;
    logic         r_da;
    logic         r_acq;
    logic         r_ccd;
    logic [W-1:0] w_pc_nxt;
    logic         w_nxt_vld;

    assign o_last = i_run && (r_pc == i_cpp - W'(1));

    // Strobes register off the next pc so each lands in the cycle pc == delay.
    always_comb begin
        w_nxt_vld = 1'b0;
        w_pc_nxt  = '0;
        if (i_abort) begin
            w_nxt_vld = 1'b0;
        end else if (i_start) begin
            w_nxt_vld = 1'b1;
        end else if (i_run && !o_last) begin
            w_nxt_vld = 1'b1;
            w_pc_nxt  = r_pc + W'(1);
        end
    end

    assign o_da_set = w_nxt_vld && (w_pc_nxt == i_da);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= '0;
            r_da  <= 1'b0;
            r_acq <= 1'b0;
            r_ccd <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_da  <= o_da_set;
            r_acq <= w_nxt_vld && (w_pc_nxt == i_acq);
            r_ccd <= w_nxt_vld && (w_pc_nxt == i_ccd);
        end
    end

    assign o_da  = r_da;
    assign o_acq = r_acq;
    assign o_ccd = r_ccd;

endmodule

// File: rtl/scan_trigger_sequencer.sv
// Runs one OCT scan from the latched frame config: X samples from BRAM
// to the X DAC per point, Y DAC stepped per line, triggers per point.
import oct_scan_pkg::*;

module scan_trigger_sequencer #(
    parameter int                ADDR_W    = OCT_ADDR_W,
    parameter int                DATA_W    = OCT_DATA_W,
    parameter logic [ADDR_W-1:0] X_BASE    = ADDR_W'(OCT_X_BASE),
    parameter int                ADDR_STEP = OCT_ADDR_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_done,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_x_points,
    input  logic [DATA_W-1:0] cfg_x_blocks,
    input  logic [DATA_W-1:0] cfg_y_points,
    input  logic [DATA_W-1:0] cfg_cycles_pp,
    input  logic [DATA_W-1:0] cfg_da_delay,
    input  logic [DATA_W-1:0] cfg_acq_delay,
    input  logic [DATA_W-1:0] cfg_ccd_delay,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_data,
    output logic [DATA_W-1:0] xdac_data,
    output logic              xdac_load,
    output logic [DATA_W-1:0] ydac_data,
    output logic              ydac_load,
    output logic              acq_trig,
    output logic              ccd_trig,
    output logic              busy,
    output logic              scan_done
);

    logic [2:0]        r_state;
    logic              r_fd_q;
    logic              r_fd_armed;
    logic [DATA_W-1:0] r_xp;
    logic [DATA_W-1:0] r_xb;
    logic [DATA_W-1:0] r_yp;
    logic [DATA_W-1:0] r_cpp;
    logic [DATA_W-1:0] r_da;
    logic [DATA_W-1:0] r_acq;
    logic [DATA_W-1:0] r_ccd;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_blk;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] r_xdac;
    logic [DATA_W-1:0] r_ydac;
    logic              r_ydac_load;
    logic [ADDR_W-1:0] r_addr;

    logic w_start;
    logic w_zero_cfg;
    logic w_last;
    logic w_da_set;

    function automatic logic [ADDR_W-1:0] f_addr(input logic [DATA_W-1:0] x);
        return X_BASE + ADDR_W'(ADDR_STEP) * ADDR_W'(x);
    endfunction

    // Armed flag keeps a level held high through reset from looking like an edge.
    assign w_start    = r_fd_armed && frame_done && !r_fd_q;
    assign w_zero_cfg = (r_xp == '0) || (r_xb == '0) || (r_yp == '0);

    point_timer #(
        .W        (DATA_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_start  (r_state == S_CAPT),
        .i_run    (r_state == S_POINT),
        .i_abort  (abort),
        .i_cpp    (r_cpp),
        .i_da     (r_da),
        .i_acq    (r_acq),
        .i_ccd    (r_ccd),
        .o_last   (w_last),
        .o_da_set (w_da_set),
        .o_da     (xdac_load),
        .o_acq    (acq_trig),
        .o_ccd    (ccd_trig)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fd_q      <= 1'b0;
            r_fd_armed  <= 1'b0;
            r_xp        <= '0;
            r_xb        <= '0;
            r_yp        <= '0;
            r_cpp       <= '0;
            r_da        <= '0;
            r_acq       <= '0;
            r_ccd       <= '0;
            r_x         <= '0;
            r_blk       <= '0;
            r_y         <= '0;
            r_sample    <= '0;
            r_xdac      <= '0;
            r_ydac      <= '0;
            r_ydac_load <= 1'b0;
            r_addr      <= '0;
        end else begin
            r_fd_q      <= frame_done;
            r_fd_armed  <= 1'b1;
            r_ydac_load <= 1'b0;
            if (w_da_set) begin
                r_xdac <= (r_state == S_CAPT) ? bram_data : r_sample;
            end
            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_xp    <= cfg_x_points;
                            r_xb    <= cfg_x_blocks;
                            r_yp    <= cfg_y_points;
                            r_cpp   <= (cfg_cycles_pp == '0) ?
                                       DATA_W'(1) : cfg_cycles_pp;
                            r_da    <= cfg_da_delay;
                            r_acq   <= cfg_acq_delay;
                            r_ccd   <= cfg_ccd_delay;
                            r_x     <= '0;
                            r_blk   <= '0;
                            r_y     <= '0;
                            r_state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (w_zero_cfg) begin
                            r_state <= S_DONE;
                        end else begin
                            r_ydac      <= r_y;
                            r_ydac_load <= 1'b1;
                            r_state     <= S_LINE;
                        end
                    end
                    S_LINE: begin
                        r_addr  <= f_addr('0);
                        r_state <= S_FETCH;
                    end
                    S_FETCH: begin
                        r_state <= S_CAPT;
                    end
                    S_CAPT: begin
                        r_sample <= bram_data;
                        r_state  <= S_POINT;
                    end
                    S_POINT: begin
                        if (w_last) begin
                            if (r_x < r_xp - DATA_W'(1)) begin
                                r_x     <= r_x + DATA_W'(1);
                                r_addr  <= f_addr(r_x + DATA_W'(1));
                                r_state <= S_FETCH;
                            end else if (r_blk < r_xb - DATA_W'(1)) begin
                                r_x     <= '0;
                                r_blk   <= r_blk + DATA_W'(1);
                                r_addr  <= f_addr('0);
                                r_state <= S_FETCH;
                            end else if (r_y < r_yp - DATA_W'(1)) begin
                                r_x         <= '0;
                                r_blk       <= '0;
                                r_y         <= r_y + DATA_W'(1);
                                r_ydac      <= r_y + DATA_W'(1);
                                r_ydac_load <= 1'b1;
                                r_state     <= S_LINE;
                            end else begin
                                r_x     <= '0;
                                r_blk   <= '0;
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bram_addr = r_addr;
    assign xdac_data = r_xdac;
    assign ydac_data = r_ydac;
    assign ydac_load = r_ydac_load;
    assign busy      = (r_state != S_IDLE);
    assign scan_done = (r_state == S_DONE);

endmodule
